// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: opcode encoding, load error codes
// and the ASCII-to-opcode decoder used by the program loader.
package bf_pkg;

   typedef enum logic [2:0] {
      I_INC   = 3'd0,
      I_DEC   = 3'd1,
      I_RIGHT = 3'd2,
      I_LEFT  = 3'd3,
      I_OUT   = 3'd4,
      I_IN    = 3'd5,
      I_OPEN  = 3'd6,
      I_CLOSE = 3'd7
   } t_instr;

   typedef enum logic [1:0] {
      ERR_LENGTH      = 2'd0,
      ERR_STRAY_CLOSE = 2'd1,
      ERR_UNCLOSED    = 2'd2,
      ERR_TOO_DEEP    = 2'd3
   } t_load_err;

   typedef struct packed {
      logic   valid;
      t_instr op;
   } t_decoded;

   // valid=0 marks a non-command byte that is dropped
   function automatic t_decoded bf_decode_char(input logic [7:0] ch);
      t_decoded d;
      d.valid = 1'b1;
      d.op    = I_INC;
      unique case (ch)
         8'h2B:   d.op = I_INC;
         8'h2D:   d.op = I_DEC;
         8'h3E:   d.op = I_RIGHT;
         8'h3C:   d.op = I_LEFT;
         8'h2E:   d.op = I_OUT;
         8'h2C:   d.op = I_IN;
         8'h5B:   d.op = I_OPEN;
         8'h5D:   d.op = I_CLOSE;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/bf_program_loader.sv
// Brainfuck source loader: filters ASCII stream, writes opcodes to
// program memory and checks length and bracket balance/depth.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (ignored while loading)
//   in_data/valid/last source byte stream, in_ready = accepting
//   prog_we/addr/data program memory write port
//   prog_length       instructions written so far
//   done, error       load outcome (levels), err_code = t_load_err
module bf_program_loader
   import bf_pkg::*;
#(
   parameter int PROGRAM_LENGTH = 256,
   parameter int MAX_DEPTH      = 15,
   localparam int AW = (PROGRAM_LENGTH > 1) ? $clog2(PROGRAM_LENGTH) : 1,
   localparam int CW = $clog2(PROGRAM_LENGTH + 1),
   localparam int DW = $clog2(MAX_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic          prog_we,
   output logic [AW-1:0] prog_addr,
   output logic [2:0]    prog_data,
   output logic [CW-1:0] prog_length,
   output logic          done,
   output logic          error,
   output logic [1:0]    err_code
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERROR
   } t_state;

   t_state        state;
   logic [DW-1:0] depth;
   logic [DW-1:0] depth_nxt;
   t_decoded      dec;
   logic          is_open;
   logic          is_close;
   logic          f_len;
   logic          f_stray;
   logic          f_deep;

   assign in_ready = (state == S_LOAD);

   always_comb begin
      dec       = bf_decode_char(in_data);
      is_open   = dec.valid && (dec.op == I_OPEN);
      is_close  = dec.valid && (dec.op == I_CLOSE);
      f_len     = dec.valid && (prog_length == CW'(PROGRAM_LENGTH));
      f_stray   = is_close && (depth == '0);
      f_deep    = is_open && (depth == DW'(MAX_DEPTH));
      depth_nxt = depth;
      if (is_open)
         depth_nxt = depth + DW'(1);
      else if (is_close)
         depth_nxt = depth - DW'(1);
   end

   // prog_length doubles as the write pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         depth       <= '0;
         prog_we     <= 1'b0;
         prog_addr   <= '0;
         prog_data   <= '0;
         prog_length <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= '0;
      end else begin
         prog_we <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state       <= S_LOAD;
                  depth       <= '0;
                  prog_length <= '0;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  err_code    <= ERR_LENGTH;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  if (f_len) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_LENGTH;
                  end else if (f_stray) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_STRAY_CLOSE;
                  end else if (f_deep) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_TOO_DEEP;
                  end else begin
                     if (dec.valid) begin
                        prog_we     <= 1'b1;
                        prog_addr   <= prog_length[AW-1:0];
                        prog_data   <= dec.op;
                        prog_length <= prog_length + CW'(1);
                     end
                     depth <= depth_nxt;
                     if (in_last) begin
                        if (depth_nxt != '0) begin
                           state    <= S_ERROR;
                           error    <= 1'b1;
                           err_code <= ERR_UNCLOSED;
                        end else begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
